gate_bist: RTL and testbench
============================

Name: gate_bist

Overview:
- Built-in self-test sequencer for a small combinational standard cell (default target: a 3-input NAND).
- Acts as the initiator/checker: drives every input vector into the cell under test, waits a settle interval, samples the cell output and compares it against an expected truth table.
- Sits beside a cell instance in the characterisation/test wrapper and reports pass/fail, error count and first failing vector.

Parameters:
- N_IN, 3, number of cell inputs; 2^N_IN vectors per run.
- SETTLE, 2, idle cycles between applying a vector and sampling DUT_Y (0 allowed).
- EXPECT, 8'h7F, expected truth table, width 2^N_IN; bit i = expected DUT_Y for DUT_IN == i (NAND3 = 8'h7F).

Ports:
- CLK  input  1  clock, rising edge.
- R  input  1  asynchronous active-low reset.
- START  input  1  run request, level-sampled.
- DUT_IN  output  N_IN  vector driven to the cell under test, registered.
- DUT_Y  input  1  cell output; synchronous to CLK by construction of the wrapper.
- BUSY  output  1  run in progress.
- DONE  output  1  run complete, results valid.
- PASS  output  1  1 = no mismatches; valid while DONE.
- ERR_CNT  output  N_IN+1  mismatch count.
- FAIL_IDX  output  N_IN  first failing vector index.

Behaviour:
- Reset (R low, asynchronous): state IDLE; DUT_IN=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_IDX=0, vector index=0, settle counter=0.
- States: IDLE, APPLY, WAIT, SAMPLE, FIN.
- IDLE: START=1 at an edge sets idx=0, ERR_CNT=0, FAIL_IDX=0, DONE=0, BUSY=1, DUT_IN=0, and enters APPLY.
- APPLY: 1 cycle. Next state is WAIT with settle counter=SETTLE-1, or SAMPLE directly if SETTLE=0.
- WAIT: counter decrements each cycle; leaves to SAMPLE when the counter is 0. Total WAIT duration = SETTLE cycles.
- SAMPLE: 1 cycle. At the exit edge, compare DUT_Y with EXPECT[idx].
  - On mismatch: if ERR_CNT==0, FAIL_IDX=idx; ERR_CNT++ (saturates at 2^N_IN).
  - If idx==2^N_IN-1, go to FIN. Otherwise idx++, DUT_IN=idx+1, go to APPLY.
- Per-vector cost: SETTLE+2 cycles. START edge k → DONE first high after edge k+2^N_IN*(SETTLE+2). Default: 32 cycles.
- FIN:
  - Registered at the transition: DONE=1, BUSY=0, PASS=(final ERR_CNT==0), DUT_IN=0.
  - Outputs hold. START=1 restarts exactly as from IDLE; DONE and PASS drop on that edge.
- START is ignored while BUSY; a run cannot be aborted except by R.
- Reset mid-run: all outputs return to reset values immediately, and no partial results are retained.
- ERR_CNT width N_IN+1, so all 2^N_IN vectors can fail without wrap.
- FAIL_IDX stays 0 on a passing run; ERR_CNT distinguishes "vector 0 failed" from "pass".

Optional Feature:
- Macro: GATE_BIST_OBS_EN.
- Defined:
  - Adds output OBS [2^N_IN-1:0], reset 0, cleared on run start.
  - Bit idx is written with the sampled DUT_Y at each SAMPLE exit, so OBS holds the measured truth table when DONE=1.
- Undefined: port and register absent; all other behaviour identical.

Test Plan:
1. Behavioural NAND3 on DUT_IN→DUT_Y, defaults, START pulse 1 cycle → DUT_IN steps 0..7, each held 4 cycles; DONE=1 after 32 cycles; PASS=1, ERR_CNT=0, FAIL_IDX=0, BUSY=0; (OBS_EN) OBS=8'h7F.
2. DUT_Y tied 1 → DONE after 32 cycles; PASS=0, ERR_CNT=1, FAIL_IDX=7; (OBS_EN) OBS=8'hFF.
3. DUT_Y tied 0 → PASS=0, ERR_CNT=7, FAIL_IDX=0; (OBS_EN) OBS=8'h00.
4. START held high for the entire run → single run only, DONE at cycle 32. START still high in FIN → restart: DONE and PASS drop on the next edge, and a second DONE comes 32 cycles later.
5. Assert R low at cycle 10 of a run → all outputs 0 without a clock edge. Release, then START → full 32-cycle run, PASS=1 with the NAND3 model.
6. SETTLE=0, N_IN=3, EXPECT=8'h80 with an AND3 model → each vector held 2 cycles, DONE after 16 cycles, PASS=1.

Source files
------------

// File: rtl/gate_bist.sv
// BIST sequencer: sweeps all input vectors of a small cell and checks its output.
// Optional GATE_BIST_OBS_EN adds OBS, the measured truth table.
module gate_bist #(
   parameter int N_IN = 3,
   parameter int SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0] EXPECT = 8'h7F
) (
   input  logic                CLK,
   input  logic                R,
   input  logic                START,
   output logic [N_IN-1:0]     DUT_IN,
   input  logic                DUT_Y,
   output logic                BUSY,
   output logic                DONE,
   output logic                PASS,
   output logic [N_IN:0]       ERR_CNT,
`ifdef GATE_BIST_OBS_EN
   output logic [(1<<N_IN)-1:0] OBS,
`endif
   output logic [N_IN-1:0]     FAIL_IDX
);

   localparam int NV = 1 << N_IN;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_INIT = (SETTLE > 0) ? CW'(SETTLE - 1) : '0;
   localparam logic [N_IN:0] ERR_MAX = (N_IN + 1)'(NV);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_WAIT,
      S_SAMPLE,
      S_FIN
   } state_t;

   state_t          state;
   logic [N_IN-1:0] idx;
   logic [CW-1:0]   cnt;
   logic            miss;
   logic [N_IN:0]   err_nxt;

   always_comb begin
      miss    = (DUT_Y != EXPECT[idx]);
      err_nxt = ERR_CNT;
      if (miss && (ERR_CNT != ERR_MAX))
         err_nxt = ERR_CNT + 1'b1;
   end

   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         state    <= S_IDLE;
         idx      <= '0;
         cnt      <= '0;
         DUT_IN   <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         PASS     <= 1'b0;
         ERR_CNT  <= '0;
         FAIL_IDX <= '0;
`ifdef GATE_BIST_OBS_EN
         OBS      <= '0;
`endif
      end else begin
         unique case (state)
            S_IDLE, S_FIN: begin
               if (START) begin
                  state    <= S_APPLY;
                  idx      <= '0;
                  ERR_CNT  <= '0;
                  FAIL_IDX <= '0;
                  DONE     <= 1'b0;
                  PASS     <= 1'b0;
                  BUSY     <= 1'b1;
                  DUT_IN   <= '0;
`ifdef GATE_BIST_OBS_EN
                  OBS      <= '0;
`endif
               end
            end
            S_APPLY: begin
               if (SETTLE == 0) begin
                  state <= S_SAMPLE;
               end else begin
                  state <= S_WAIT;
                  cnt   <= CNT_INIT;
               end
            end
            S_WAIT: begin
               if (cnt == '0)
                  state <= S_SAMPLE;
               else
                  cnt <= cnt - 1'b1;
            end
            S_SAMPLE: begin
               ERR_CNT <= err_nxt;
               // only the first mismatch of a run is latched
               if (miss && (ERR_CNT == '0))
                  FAIL_IDX <= idx;
`ifdef GATE_BIST_OBS_EN
               OBS[idx] <= DUT_Y;
`endif
               if (idx == '1) begin
                  state  <= S_FIN;
                  DONE   <= 1'b1;
                  BUSY   <= 1'b0;
                  PASS   <= (err_nxt == '0);
                  DUT_IN <= '0;
               end else begin
                  state  <= S_APPLY;
                  idx    <= idx + 1'b1;
                  DUT_IN <= idx + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_bist.sv
// Scoreboard bench for gate_bist: random cell truth tables vs. a table-level model.
// Two instances: defaults (NAND3, SETTLE=2) and SETTLE=0 with an AND3 expectation.
module tb_gate_bist;

   logic       CLK = 1'b0;
   logic       R = 1'b0;
   logic       start0 = 1'b0, start1 = 1'b0;
   logic [2:0] din0, din1, fidx0, fidx1;
   logic [3:0] err0, err1;
   logic       busy0, busy1, done0, done1, pass0, pass1;
   logic [7:0] tbl0 = 8'h7F, tbl1 = 8'h80;
   logic       y0, y1;
`ifdef GATE_BIST_OBS_EN
   logic [7:0] obs0, obs1;
`endif

   assign y0 = tbl0[din0];
   assign y1 = tbl1[din1];

   always #5 CLK = ~CLK;

   gate_bist u_dut0 (
      .CLK(CLK), .R(R), .START(start0), .DUT_IN(din0), .DUT_Y(y0),
      .BUSY(busy0), .DONE(done0), .PASS(pass0), .ERR_CNT(err0),
`ifdef GATE_BIST_OBS_EN
      .OBS(obs0),
`endif
      .FAIL_IDX(fidx0)
   );

   gate_bist #(.N_IN(3), .SETTLE(0), .EXPECT(8'h80)) u_dut1 (
      .CLK(CLK), .R(R), .START(start1), .DUT_IN(din1), .DUT_Y(y1),
      .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_CNT(err1),
`ifdef GATE_BIST_OBS_EN
      .OBS(obs1),
`endif
      .FAIL_IDX(fidx1)
   );

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         inst;
      int         done_cyc;
      bit         pass;
      int         err;
      int         fidx;
      logic [7:0] obs;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0d required %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input int inst, input logic [7:0] tbl,
                                  input logic [7:0] expt, input int done_cyc);
      exp_t e;
      logic [7:0] d;
      d = tbl ^ expt;
      e.inst = inst;
      e.done_cyc = done_cyc;
      e.err = $countones(d);
      e.pass = (d == 8'h00);
      e.fidx = 0;
      for (int i = 7; i >= 0; i--)
         if (d[i]) e.fidx = i;
      e.obs = tbl;
      return e;
   endfunction

   logic prev_done [2];
   int   bc [2];
   int   bad [2];

   always @(negedge CLK) begin
      for (int i = 0; i < 2; i++) begin
         logic bs, dn, ps;
         int dv, ev, fv, sp;
         logic [7:0] ob;
         exp_t e;
         bs = (i == 0) ? busy0 : busy1;
         dn = (i == 0) ? done0 : done1;
         ps = (i == 0) ? pass0 : pass1;
         dv = (i == 0) ? int'(din0) : int'(din1);
         ev = (i == 0) ? int'(err0) : int'(err1);
         fv = (i == 0) ? int'(fidx0) : int'(fidx1);
         sp = (i == 0) ? 4 : 2;
`ifdef GATE_BIST_OBS_EN
         ob = (i == 0) ? obs0 : obs1;
`else
         ob = 8'h00;
`endif
         if (!R) begin
            bc[i] = 0;
            bad[i] = 0;
            prev_done[i] = 1'b0;
         end else begin
            if (bs) begin
               if (dv != bc[i] / sp) bad[i]++;
               bc[i]++;
            end
            if (dn && !prev_done[i]) begin
               if (q.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = q.pop_front();
                  chk("inst", i, e.inst);
                  chk("done_cycle", cyc, e.done_cyc);
                  chk("pass", int'(ps), int'(e.pass));
                  chk("err_cnt", ev, e.err);
                  chk("fail_idx", fv, e.fidx);
                  chk("busy_at_done", int'(bs), 0);
                  chk("dut_in_at_done", dv, 0);
                  chk("vector_trace_bad", bad[i], 0);
                  chk("vector_trace_len", bc[i], 8 * sp);
`ifdef GATE_BIST_OBS_EN
                  chk("obs", int'(ob), int'(e.obs));
`endif
               end
               bc[i] = 0;
               bad[i] = 0;
            end
            prev_done[i] = dn;
         end
      end
   end

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (q.size() != 0 && n < budget) begin
         @(negedge CLK);
         n++;
      end
      if (q.size() != 0) begin
         chk("done_timeout", q.size(), 0);
         q.delete();
      end
   endtask

   task automatic run(input int inst, input logic [7:0] tbl);
      int sp;
      sp = (inst == 0) ? 4 : 2;
      @(negedge CLK);
      if (inst == 0) tbl0 = tbl;
      else tbl1 = tbl;
      q.push_back(model(inst, tbl, (inst == 0) ? 8'h7F : 8'h80, cyc + 1 + 8 * sp));
      if (inst == 0) start0 = 1'b1;
      else start1 = 1'b1;
      @(negedge CLK);
      start0 = 1'b0;
      start1 = 1'b0;
      wait_idle(100);
   endtask

   function automatic int outs0();
`ifdef GATE_BIST_OBS_EN
      return int'({obs0, busy0, done0, pass0, err0, fidx0, din0});
`else
      return int'({busy0, done0, pass0, err0, fidx0, din0});
`endif
   endfunction

   initial begin
      int k;
      logic [7:0] t;
      R = 1'b0;
      repeat (3) @(negedge CLK);
      chk("reset_state", outs0(), 0);
      R = 1'b1;

      run(0, 8'h7F);
      run(0, 8'hFF);
      run(0, 8'h00);
      repeat (6) begin
         t = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) t = 8'h7F;
         run(0, t);
      end

      @(negedge CLK);
      tbl0 = 8'h7F;
      k = cyc + 1;
      q.push_back(model(0, 8'h7F, 8'h7F, k + 32));
      q.push_back(model(0, 8'h7F, 8'h7F, k + 65));
      start0 = 1'b1;
      repeat (34) @(negedge CLK);
      chk("restart_drops_done_pass", int'({done0, pass0}), 0);
      chk("restart_busy", int'(busy0), 1);
      start0 = 1'b0;
      wait_idle(100);

      @(negedge CLK);
      start0 = 1'b1;
      @(negedge CLK);
      start0 = 1'b0;
      repeat (9) @(negedge CLK);
      chk("busy_before_reset", int'(busy0), 1);
      #2 R = 1'b0;
      #1 chk("async_reset_mid_run", outs0(), 0);
      repeat (2) @(negedge CLK);
      R = 1'b1;
      run(0, 8'h7F);

      run(1, 8'h80);
      repeat (4) begin
         t = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) t = 8'h80;
         run(1, t);
      end

      repeat (3) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
